// File: rtl/divider_pkg.sv
// Shared constants for the buffered restoring divider: FSM states and operand-select codes.
package divider_pkg;

  localparam int unsigned DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_DVD_LO = 2'b01;
  localparam logic [1:0] SEL_DVD_HI = 2'b10;
  localparam logic [1:0] SEL_DVS    = 2'b11;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, trial-subtract.
module divider_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_work_msb,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_rem_nxt_c,
  output logic         o_q_bit_c
);

  // N+1 bits so the shifted-in value can exceed the divisor before subtraction
  logic [N:0] w_r;

  assign w_r         = {i_rem, i_work_msb};
  assign o_q_bit_c   = (w_r >= {1'b0, i_divisor});
  assign o_rem_nxt_c = o_q_bit_c ? N'(w_r - {1'b0, i_divisor}) : N'(w_r);

endmodule

// File: rtl/divider_n_bits_buffer.sv
// Buffered 2N/N restoring divider: operands loaded piecewise from a shared bus,
// one quotient bit per clock, results held until the next completion.
module divider_n_bits_buffer
  import divider_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   data_in,
  input  logic [1:0]     load_sel,
  input  logic           start,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_zero
);

  localparam int unsigned       CNT_W     = $clog2(2 * N) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * N - 1);

  state_t           r_state, w_state_nxt;
  logic [2*N-1:0]   r_dvd, w_dvd_nxt;
  logic [N-1:0]     r_dvs, w_dvs_nxt;
  logic [2*N-1:0]   r_work, w_work_nxt;
  logic [N-1:0]     r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2*N-1:0]   r_quot, w_quot_nxt;
  logic [N-1:0]     r_remd, w_remd_nxt;
  logic             r_dz, w_dz_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [N-1:0]     w_step_rem;
  logic             w_q_bit;

  divider_step #(.N(N)) u_step (
    .i_rem       (r_rem),
    .i_work_msb  (r_work[2*N-1]),
    .i_divisor   (r_dvs),
    .o_rem_nxt_c (w_step_rem),
    .o_q_bit_c   (w_q_bit)
  );

  // Next-state, datapath and output-register update logic
  always_comb begin
    w_state_nxt = r_state;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_work_nxt  = r_work;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_quot_nxt  = r_quot;
    w_remd_nxt  = r_remd;
    w_dz_nxt    = r_dz;

    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        // start takes priority; a coincident load is dropped
        if (start) begin
          if (r_dvs != '0) begin
            w_state_nxt = RUN;
            w_work_nxt  = r_dvd;
            w_rem_nxt   = '0;
            w_cnt_nxt   = '0;
            w_dz_nxt    = 1'b0;
          end else begin
            w_state_nxt = DONE;
            w_quot_nxt  = '1;
            w_remd_nxt  = r_dvd[N-1:0];
            w_dz_nxt    = 1'b1;
          end
        end else begin
          case (load_sel)
            SEL_DVD_LO: w_dvd_nxt[N-1:0]   = data_in;
            SEL_DVD_HI: w_dvd_nxt[2*N-1:N] = data_in;
            SEL_DVS:    w_dvs_nxt          = data_in;
            default:    ;
          endcase
        end
      end
      RUN: begin
        w_work_nxt = {r_work[2*N-2:0], w_q_bit};
        w_rem_nxt  = w_step_rem;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST_STEP) begin
          w_state_nxt = DONE;
          w_quot_nxt  = {r_work[2*N-2:0], w_q_bit};
          w_remd_nxt  = w_step_rem;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == RUN);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_work  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_work  <= w_work_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_quot  <= w_quot_nxt;
      r_remd  <= w_remd_nxt;
      r_dz    <= w_dz_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_divider_n_bits_buffer.sv
// Randomised self-checking bench: an arithmetic reference model is compared every cycle,
// plus hand-computed literal results for the directed scenarios.
module tb_divider_n_bits_buffer;

  localparam int unsigned N = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    data_in = '0;
  logic [1:0]      load_sel = '0;
  logic            start = 1'b0;
  logic [2*N-1:0]  quotient;
  logic [N-1:0]    remainder;
  logic            busy;
  logic            done;
  logic            div_zero;

  divider_n_bits_buffer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load_sel  (load_sel),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference model: operand buffers, a countdown to completion and the pending result
  logic [15:0] m_dvd, m_q, m_pq;
  logic [7:0]  m_dvs, m_r, m_pr;
  logic        m_dz, m_done;
  int          m_timer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dvd <= '0; m_dvs <= '0; m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0;
      m_dz <= 1'b0; m_done <= 1'b0; m_timer <= 0;
    end else if (m_timer != 0) begin
      m_timer <= m_timer - 1;
      m_done  <= (m_timer == 1);
      if (m_timer == 1) begin
        m_q <= m_pq;
        m_r <= m_pr;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (m_dvs != 0) begin
          m_timer <= 2 * N;
          m_pq    <= m_dvd / {8'h00, m_dvs};
          m_pr    <= 8'(m_dvd % {8'h00, m_dvs});
          m_dz    <= 1'b0;
        end else begin
          m_done <= 1'b1;
          m_q    <= 16'hFFFF;
          m_r    <= m_dvd[7:0];
          m_dz   <= 1'b1;
        end
      end else begin
        case (load_sel)
          2'b01:   m_dvd[7:0]  <= data_in;
          2'b10:   m_dvd[15:8] <= data_in;
          2'b11:   m_dvs       <= data_in;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en)
      chk("cycle_outputs", 32'({busy, done, div_zero, remainder, quotient}),
          32'({m_timer != 0, m_done, m_dz, m_r, m_q}));
  end

  task automatic load_ops(input logic [15:0] dvd, input logic [7:0] dvs);
    load_sel = 2'b01; data_in = dvd[7:0];  @(negedge clk);
    load_sel = 2'b10; data_in = dvd[15:8]; @(negedge clk);
    load_sel = 2'b11; data_in = dvs;       @(negedge clk);
    load_sel = 2'b00;
  endtask

  // Waits for done; with noise, scrambles inputs while busy (they must be ignored)
  task automatic wait_done(input bit noise, output int lat, output bit seen_busy);
    lat = 0;
    seen_busy = 1'b0;
    while (!done && lat < 40) begin
      if (busy) seen_busy = 1'b1;
      if (noise) begin
        if (busy) begin
          load_sel = 2'($urandom); data_in = 8'($urandom); start = 1'($urandom);
        end else begin
          load_sel = 2'b00; start = 1'b0;
        end
      end
      @(negedge clk);
      lat++;
    end
    if (noise) begin
      load_sel = 2'b00; start = 1'b0;
    end
    if (!done) chk("done_timeout", 32'(done), 32'(1));
  endtask

  task automatic start_and_check(input string name, input logic [7:0] dvs_used,
                                 input logic [15:0] exp_q, input logic [7:0] exp_r, input bit noise);
    int lat;
    bit sb;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(noise, lat, sb);
    chk({name, "_q"},       32'(quotient),  32'(exp_q));
    chk({name, "_r"},       32'(remainder), 32'(exp_r));
    chk({name, "_dz"},      32'(div_zero),  32'(dvs_used == 0));
    chk({name, "_latency"}, 32'(lat),       (dvs_used == 0) ? 32'(0) : 32'(16));
    chk({name, "_busy"},    32'(sb),        32'(dvs_used != 0));
    chk({name, "_model_q"}, 32'(m_q),       32'(exp_q));
  endtask

  task automatic div_check(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic [15:0] exp_q, input logic [7:0] exp_r, input bit noise);
    load_ops(dvd, dvs);
    start_and_check(name, dvs, exp_q, exp_r, noise);
  endtask

  initial begin
    int lat, t1, t2;
    bit sb;
    logic [15:0] rd;
    logic [7:0]  rv;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, div_zero, remainder, quotient}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    div_check("basic_03E8_07", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0);
    div_check("max_FFFF_FF",   16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
    div_check("max_FFFF_01",   16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
    div_check("divzero_0005",  16'h0005, 8'h00, 16'hFFFF, 8'h05, 1'b0);
    div_check("clear_dz",      16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0);

    // Load and start pulse during RUN must be ignored
    load_ops(16'h00FF, 8'h10);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    load_sel = 2'b11; data_in = 8'h01; start = 1'b1;
    @(negedge clk);
    load_sel = 2'b00; start = 1'b0;
    wait_done(1'b0, lat, sb);
    chk("run_ignore_q",   32'(quotient),  32'h000F);
    chk("run_ignore_r",   32'(remainder), 32'h0F);
    chk("run_ignore_lat", 32'(lat + 4),   32'(16));

    // Start coincident with a divisor load uses the old divisor and drops the load
    load_sel = 2'b11; data_in = 8'h03;
    start_and_check("start_vs_load", 8'h10, 16'h000F, 8'h0F, 1'b0);
    start_and_check("load_dropped",  8'h10, 16'h000F, 8'h0F, 1'b0);

    // Asynchronous reset in the middle of RUN
    load_ops(16'h03E8, 8'h07);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy, done, div_zero, remainder, quotient}), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_and_check("operands_cleared", 8'h00, 16'hFFFF, 8'h00, 1'b0);
    div_check("after_reset", 16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0);

    // Back-to-back divisions with start held high
    load_ops(16'h03E8, 8'h07);
    start = 1'b1;
    t1 = 0; t2 = 0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    t1 = cyc;
    for (int i = 0; i < 40 && done; i++) @(negedge clk);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    t2 = cyc;
    start = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'(17));
    chk("b2b_q",       32'(quotient), 32'h008E);
    @(negedge clk);

    // Randomised divisions with input noise during RUN
    for (int i = 0; i < 24; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rv = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if (rv == 0)
        div_check("random", rd, rv, 16'hFFFF, rd[7:0], 1'b1);
      else
        div_check("random", rd, rv, rd / {8'h00, rv}, 8'(rd % {8'h00, rv}), 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
